// File: rtl/sprite_line_queue_if.sv
// Query handshake between the sprite line queue and the renderer's
// object fetcher. The fetcher (master) asks for an X position and
// accepts matching sprites one at a time; the queue (slave) answers.
interface sprite_line_queue_if #(
  parameter int IDX_W = 6
);
  logic             query_en;
  logic [7:0]       query_x;
  logic             q_valid;
  logic             q_ready;
  logic [2:0]       q_row;
  logic [7:0]       q_tile;
  logic [3:0]       q_attrs;
  logic [IDX_W-1:0] q_idx;

  modport master (
    output query_en, query_x, q_ready,
    input  q_valid, q_row, q_tile, q_attrs, q_idx
  );

  modport slave (
    input  query_en, query_x, q_ready,
    output q_valid, q_row, q_tile, q_attrs, q_idx
  );
endinterface

// File: rtl/sprite_line_queue.sv
// Per-line sprite selector. An OAM scan walks N_OAM entries (two words
// each) and keeps up to N_SLOTS sprites that cover the current line,
// already Y-flip and 8x16 corrected. During draw the renderer queries by
// X and receives every matching sprite in OAM-index order, one per
// valid/ready handshake.
module sprite_line_queue #(
  parameter int N_SLOTS = 10,
  parameter int N_OAM   = 40,
  parameter int IDX_W   = $clog2(N_OAM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           clear,
  input  logic [7:0]                     ly,
  input  logic                           tall,
  output logic [$clog2(2*N_OAM)-1:0]     oam_addr,
  input  logic [15:0]                    oam_d_in,
  output logic                           scan_done,
  output logic                           overflow,
  output logic [$clog2(N_SLOTS+1)-1:0]   count,
  sprite_line_queue_if.slave             qif
);

  localparam int AW = $clog2(2*N_OAM);
  localparam int CW = $clog2(N_SLOTS+1);
  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(2*N_OAM-1);

  typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

  // Control state (reset)
  state_t           r_state;
  logic [AW-1:0]    r_oam_addr;
  logic             r_scan_done;
  logic             r_overflow;
  logic [7:0]       r_ly;
  logic             r_tall;
  logic [N_SLOTS-1:0] r_valid;

  // Payload storage (no reset, qualified by r_valid)
  logic [7:0]       r_y_buf;
  logic [7:0]       r_x_buf;
  logic [7:0]       r_sx    [N_SLOTS];
  logic [2:0]       r_row   [N_SLOTS];
  logic [7:0]       r_tile  [N_SLOTS];
  logic [3:0]       r_attrs [N_SLOTS];
  logic [IDX_W-1:0] r_idx   [N_SLOTS];

  logic [7:0]       w_dy;
  logic             w_visible;
  logic [3:0]       w_dyc;
  logic [7:0]       w_tile;
  logic             w_odd;
  logic             w_last;
  logic             w_free_hit;
  logic [SW-1:0]    w_free_slot;
  logic             w_match_hit;
  logic [SW-1:0]    w_match_slot;
  logic             w_store;
  logic             w_drop;
  logic             w_q_valid;
  logic             w_fire;
  logic [CW-1:0]    w_count;

  // Line offset into the sprite, visibility and flip/tall correction for
  // the entry whose second word is on the bus this cycle.
  assign w_dy      = r_ly - r_y_buf + 8'd16;
  assign w_visible = r_tall ? (w_dy < 8'd16) : (w_dy < 8'd8);
  assign w_dyc     = !oam_d_in[14] ? w_dy[3:0] :
                     r_tall        ? (4'd15 - w_dy[3:0]) :
                                     {1'b0, 3'd7 - w_dy[2:0]};
  assign w_tile    = r_tall ? {oam_d_in[7:1], w_dyc[3]} : oam_d_in[7:0];

  assign w_odd   = (r_state == SCAN) && r_oam_addr[0];
  assign w_last  = (r_oam_addr == LAST_ADDR);
  assign w_store = w_odd && w_visible && w_free_hit && !start && !clear;
  assign w_drop  = w_odd && w_visible && !w_free_hit;

  // Lowest-numbered empty slot; iterating downwards lets the lowest win.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_free_hit  = 1'b0;
    w_free_slot = '0;
    for (int s = N_SLOTS-1; s >= 0; s--) begin
      if (!r_valid[s]) begin
        w_free_hit  = 1'b1;
        w_free_slot = SW'(s);
      end
    end
  end

  // Lowest-numbered occupied slot whose X equals the query.
  always_comb begin
    w_match_hit  = 1'b0;
    w_match_slot = '0;
    for (int s = N_SLOTS-1; s >= 0; s--) begin
      if (r_valid[s] && (r_sx[s] == qif.query_x)) begin
        w_match_hit  = 1'b1;
        w_match_slot = SW'(s);
      end
    end
  end

  // Occupied-slot count.
  always_comb begin
    w_count = '0;
    for (int s = 0; s < N_SLOTS; s++) begin
      w_count = w_count + CW'(r_valid[s]);
    end
  end

  assign w_q_valid = qif.query_en && (r_state == READY) && w_match_hit;
  assign w_fire    = w_q_valid && qif.q_ready;

  // Scan/query FSM with occupancy bits; start beats clear.
  // NOTE: state registers use non-blocking assignments so every reader
  // sees the pre-edge value regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_oam_addr  <= '0;
      r_scan_done <= 1'b0;
      r_overflow  <= 1'b0;
      r_ly        <= '0;
      r_tall      <= 1'b0;
      r_valid     <= '0;
    end else if (start) begin
      r_state     <= SCAN;
      r_oam_addr  <= '0;
      r_scan_done <= 1'b0;
      r_overflow  <= 1'b0;
      r_ly        <= ly;
      r_tall      <= tall;
      r_valid     <= '0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_scan_done <= 1'b0;
      r_valid     <= '0;
    end else begin
      case (r_state)
        SCAN: begin
          if (w_store) r_valid[w_free_slot] <= 1'b1;
          if (w_drop)  r_overflow <= 1'b1;
          if (w_last) begin
            r_state     <= READY;
            r_scan_done <= 1'b1;
          end else begin
            r_oam_addr <= r_oam_addr + 1'b1;
          end
        end
        READY: begin
          if (w_fire) r_valid[w_match_slot] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Even-word buffer and slot payload writes.
  // NOTE: payload arrays are deliberately not reset; r_valid alone decides
  // whether a slot holds a sprite, so stale data is never observable.
  always_ff @(posedge clk) begin
    if ((r_state == SCAN) && !r_oam_addr[0]) begin
      r_y_buf <= oam_d_in[7:0];
      r_x_buf <= oam_d_in[15:8];
    end
    if (w_store) begin
      r_sx[w_free_slot]    <= r_x_buf;
      r_row[w_free_slot]   <= w_dyc[2:0];
      r_tile[w_free_slot]  <= w_tile;
      r_attrs[w_free_slot] <= oam_d_in[15:12];
      r_idx[w_free_slot]   <= IDX_W'(r_oam_addr >> 1);
    end
  end

  assign oam_addr  = r_oam_addr;
  assign scan_done = r_scan_done;
  assign overflow  = r_overflow;
  assign count     = w_count;

  assign qif.q_valid = w_q_valid;
  assign qif.q_row   = r_row[w_match_slot];
  assign qif.q_tile  = r_tile[w_match_slot];
  assign qif.q_attrs = r_attrs[w_match_slot];
  assign qif.q_idx   = r_idx[w_match_slot];

endmodule

// File: tb/tb_sprite_line_queue.sv
// Bench for sprite_line_queue: an OAM memory model, a reference model of
// the line selection feeding a scoreboard queue, and query drains that pop
// and compare each delivered sprite.
module tb_sprite_line_queue;

  localparam int N_SLOTS = 10;
  localparam int N_OAM   = 40;
  localparam int IDX_W   = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        tall = 1'b0;
  logic [7:0]  ly = 8'd0;
  logic [6:0]  oam_addr;
  logic [15:0] oam_d_in;
  logic        scan_done;
  logic        overflow;
  logic [3:0]  count;
  logic [15:0] oam_mem [2*N_OAM];

  always #5 clk = ~clk;

  sprite_line_queue_if #(.IDX_W(IDX_W)) qif ();

  sprite_line_queue #(.N_SLOTS(N_SLOTS), .N_OAM(N_OAM), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .start     (start),
    .clear     (clear),
    .ly        (ly),
    .tall      (tall),
    .oam_addr  (oam_addr),
    .oam_d_in  (oam_d_in),
    .scan_done (scan_done),
    .overflow  (overflow),
    .count     (count),
    .qif       (qif)
  );

  assign oam_d_in = oam_mem[oam_addr];

  typedef struct {
    int         idx;
    logic [7:0] x;
    logic [2:0] row;
    logic [7:0] tile;
    logic [3:0] attrs;
  } exp_t;

  exp_t exp_q[$];
  logic exp_ovf;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_oam();
    for (int i = 0; i < N_OAM; i++) begin
      oam_mem[2*i]   = {8'd200, 8'd0};
      oam_mem[2*i+1] = 16'h0000;
    end
  endtask

  task automatic set_entry(input int i, input logic [7:0] y, input logic [7:0] x,
                           input logic [7:0] tile_v, input logic [7:0] attrs_v);
    oam_mem[2*i]   = {x, y};
    oam_mem[2*i+1] = {attrs_v, tile_v};
  endtask

  // Reference selection: every visible entry in index order, first N_SLOTS kept.
  task automatic build_model(input logic [7:0] l, input logic t);
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < N_OAM; i++) begin
      int         dy, dyc, lim;
      logic [7:0] y, a, tl;
      exp_t       e;
      y   = oam_mem[2*i][7:0];
      tl  = oam_mem[2*i+1][7:0];
      a   = oam_mem[2*i+1][15:8];
      dy  = (int'(l) - int'(y) + 16) & 255;
      lim = t ? 16 : 8;
      if (dy < lim) begin
        if (exp_q.size() == N_SLOTS) begin
          exp_ovf = 1'b1;
        end else begin
          dyc     = a[6] ? (lim - 1 - dy) : dy;
          e.idx   = i;
          e.x     = oam_mem[2*i][15:8];
          e.row   = 3'(dyc % 8);
          e.tile  = t ? ((tl & 8'hFE) | 8'(dyc / 8)) : tl;
          e.attrs = a[7:4];
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic start_scan(input logic [7:0] l, input logic t, input logic with_clear);
    build_model(l, t);
    @(negedge clk);
    start = 1'b1;
    clear = with_clear;
    ly    = l;
    tall  = t;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
  endtask

  task automatic wait_scan(input int c0);
    int cycles;
    cycles = c0;
    while (scan_done !== 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check("scan_cycles", cycles, 80);
    check("scan_done", scan_done, 1);
    check("count_after_scan", count, exp_q.size());
    check("overflow", overflow, exp_ovf);
  endtask

  task automatic do_scan(input logic [7:0] l, input logic t);
    start_scan(l, t, 1'b0);
    wait_scan(0);
  endtask

  // Pop every expected sprite at X x and compare them one per cycle.
  task automatic drain(input logic [7:0] x);
    exp_t hits[$];
    exp_t rest[$];
    foreach (exp_q[k]) begin
      if (exp_q[k].x == x) hits.push_back(exp_q[k]);
      else                 rest.push_back(exp_q[k]);
    end
    exp_q = rest;
    @(negedge clk);
    qif.query_en = 1'b1;
    qif.query_x  = x;
    qif.q_ready  = 1'b1;
    foreach (hits[k]) begin
      #1;
      check("q_valid", qif.q_valid, 1);
      check("q_idx", qif.q_idx, hits[k].idx);
      check("q_row", qif.q_row, hits[k].row);
      check("q_tile", qif.q_tile, hits[k].tile);
      check("q_attrs", qif.q_attrs, hits[k].attrs);
      @(negedge clk);
    end
    #1;
    check("q_valid_end", qif.q_valid, 0);
    check("count_after_drain", count, exp_q.size());
    qif.query_en = 1'b0;
    qif.q_ready  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_oam();
    qif.query_en = 1'b1;
    qif.query_x  = 8'd200;
    qif.q_ready  = 1'b0;
    #3;
    check("rst_oam_addr", oam_addr, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", count, 0);
    check("rst_q_valid", qif.q_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    qif.query_en = 1'b0;

    // Single sprite, normal height, no flip.
    set_entry(3, 8'd36, 8'd50, 8'h12, 8'h00);
    start_scan(8'd20, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    qif.query_en = 1'b1;
    qif.query_x  = 8'd50;
    #1;
    check("q_valid_in_scan", qif.q_valid, 0);
    qif.query_en = 1'b0;
    wait_scan(40);
    @(negedge clk);
    qif.query_en = 1'b1;
    qif.query_x  = 8'd50;
    qif.q_ready  = 1'b0;
    #1;
    check("q_valid_hold", qif.q_valid, 1);
    @(negedge clk);
    #1;
    check("q_valid_still", qif.q_valid, 1);
    check("count_no_ready", count, 1);
    qif.query_en = 1'b0;
    drain(8'd50);

    // Tall sprite with Y-flip: dy=14 -> dyc=1, tile low bit cleared.
    clear_oam();
    set_entry(0, 8'd32, 8'd8, 8'h21, 8'h40);
    do_scan(8'd30, 1'b1);
    @(negedge clk);
    qif.query_en = 1'b1;
    qif.query_x  = 8'd8;
    #1;
    check("tall_row", qif.q_row, 1);
    check("tall_tile", qif.q_tile, 8'h20);
    qif.query_en = 1'b0;
    drain(8'd8);

    // Twelve visible entries: overflow, entries 10 and 11 never returned.
    clear_oam();
    for (int i = 0; i < 12; i++) begin
      set_entry(i, 8'(36 - (i % 8)), 8'(60 + i), 8'(8'h30 + i),
                (i % 2 == 1) ? 8'hC0 : 8'h30);
    end
    do_scan(8'd20, 1'b0);
    for (int x = 60; x < 65; x++) drain(8'(x));
    for (int x = 70; x < 72; x++) drain(8'(x));
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_q.delete();
    #1;
    check("clear_scan_done", scan_done, 0);
    check("clear_overflow_hold", overflow, 1);
    check("clear_count", count, 0);
    qif.query_en = 1'b1;
    qif.query_x  = 8'd65;
    #1;
    check("clear_q_valid", qif.q_valid, 0);
    qif.query_en = 1'b0;

    // Two sprites sharing X are returned in OAM-index order.
    clear_oam();
    set_entry(5, 8'd36, 8'd40, 8'h55, 8'h10);
    set_entry(2, 8'd33, 8'd40, 8'h22, 8'h20);
    set_entry(7, 8'd34, 8'd41, 8'h77, 8'h40);
    do_scan(8'd20, 1'b0);
    drain(8'd40);
    drain(8'd41);

    // Asynchronous reset in the middle of a scan.
    clear_oam();
    set_entry(1, 8'd36, 8'd90, 8'h09, 8'h00);
    start_scan(8'd20, 1'b0, 1'b0);
    repeat (37) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_oam_addr", oam_addr, 0);
    check("midrst_count", count, 0);
    check("midrst_scan_done", scan_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_scan(8'd20, 1'b0);
    drain(8'd90);

    // Restart from READY (with a simultaneous clear, which start overrides).
    clear_oam();
    set_entry(10, 8'd36, 8'd100, 8'hA0, 8'h00);
    set_entry(11, 8'd35, 8'd101, 8'hA1, 8'h40);
    set_entry(12, 8'd30, 8'd102, 8'hA2, 8'h80);
    do_scan(8'd20, 1'b0);
    start_scan(8'd20, 1'b0, 1'b1);
    #1;
    check("rescan_count", count, 0);
    check("rescan_done", scan_done, 0);
    wait_scan(0);
    drain(8'd100);
    drain(8'd101);
    drain(8'd102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
